// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions.
//   XLEN          : integer register / address width
//   NOP           : canonical no-op encoding (addi x0, x0, 0)
//   fetch_state_t : fetch stage sequencing states
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FAULT_EMIT,
        FAULT_HOLD
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: holds the PC, drives the word-indexed instruction
// memory read port and captures fetched words into the IF/ID register, which
// is handed to decode with a valid/ready handshake. Execute redirects flush
// the IF/ID register and reload the PC; a misaligned redirect target produces
// exactly one fault bundle and then parks the stage until the next redirect.
//
// Ports:
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   fetch_en            : fetch permitted (low while memory is being loaded)
//   redirect_valid/_pc  : PC change request from execute (byte address)
//   inst_mem_read_addr  : word index {2'b00, pc[31:2]} to instruction memory
//   inst                : combinational read data for inst_mem_read_addr
//   id_valid/id_ready   : IF/ID handshake toward decode
//   id_pc, id_pc_plus4  : byte PC of the bundle and PC + 4 (wrapping)
//   id_inst, id_fault   : instruction word and misaligned-fetch marker
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] inst_mem_read_addr,
    input  logic [XLEN-1:0] inst,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4,
    output logic [XLEN-1:0] id_inst,
    output logic            id_fault
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            advance;

    assign pc_plus4           = pc + 32'd4;
    assign advance            = !id_valid || id_ready;
    assign inst_mem_read_addr = {2'b00, pc[XLEN-1:2]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            id_valid    <= 1'b0;
            id_pc       <= '0;
            id_pc_plus4 <= '0;
            id_inst     <= NOP;
            id_fault    <= 1'b0;
        end else if (redirect_valid) begin
            // Redirect wins in every state and drops any stalled bundle.
            id_valid <= 1'b0;
            pc       <= redirect_pc;
            if (redirect_pc[1:0] != 2'b00) begin
                state <= FAULT_EMIT;
            end else if (fetch_en) begin
                state <= RUN;
            end else begin
                state <= IDLE;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (advance) begin
                        id_valid <= 1'b0;
                    end
                    // No fetch in the cycle that leaves IDLE.
                    if (fetch_en) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (advance) begin
                        if (fetch_en) begin
                            id_pc       <= pc;
                            id_pc_plus4 <= pc_plus4;
                            id_inst     <= inst;
                            id_fault    <= 1'b0;
                            id_valid    <= 1'b1;
                            pc          <= pc_plus4;
                        end else begin
                            id_valid <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                FAULT_EMIT: begin
                    // Entered only through a redirect, which cleared id_valid,
                    // so the fault bundle is always captured here.
                    if (advance) begin
                        id_pc       <= pc;
                        id_pc_plus4 <= pc_plus4;
                        id_inst     <= NOP;
                        id_fault    <= 1'b1;
                        id_valid    <= 1'b1;
                    end
                    state <= FAULT_HOLD;
                end
                FAULT_HOLD: begin
                    if (advance) begin
                        id_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed vector table, hand-written corner
// sequences (PC wrap, fetch_en drop, asynchronous reset) and a randomized
// phase compared against a behavioural model of the stage.
module tb_fetch_stage;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] NOP = riscv_pkg::NOP;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] inst_mem_read_addr;
    logic [31:0] inst;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_inst;
    logic        id_fault;

    int checks   = 0;
    int failures = 0;

    fetch_stage #(.RESET_PC(RPC)) dut (
        .clk                (clk),
        .rst                (rst),
        .fetch_en           (fetch_en),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .inst_mem_read_addr (inst_mem_read_addr),
        .inst               (inst),
        .id_valid           (id_valid),
        .id_ready           (id_ready),
        .id_pc              (id_pc),
        .id_pc_plus4        (id_pc_plus4),
        .id_inst            (id_inst),
        .id_fault           (id_fault)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: a distinct word for every word index.
    function automatic logic [31:0] mem_word(input logic [31:0] widx);
        return {widx[15:0], widx[15:0] ^ 16'hBEEF};
    endfunction

    assign inst = mem_word(inst_mem_read_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_bpc;
    logic [31:0] m_inst;
    logic        m_fault;
    logic        m_running;    // fetching sequentially
    logic        m_fault_due;  // a misaligned target still owes its fault bundle
    logic        m_parked;     // fault delivered, waiting for a redirect

    task automatic m_reset();
        m_pc = RPC; m_valid = 1'b0; m_bpc = '0; m_inst = NOP; m_fault = 1'b0;
        m_running = 1'b0; m_fault_due = 1'b0; m_parked = 1'b0;
    endtask

    task automatic m_edge();
        bit consumed;
        consumed = !m_valid || id_ready;
        if (redirect_valid) begin
            m_valid     = 1'b0;
            m_pc        = redirect_pc;
            m_fault_due = (redirect_pc % 4) != 0;
            m_parked    = 1'b0;
            m_running   = !m_fault_due && fetch_en;
        end else if (m_fault_due) begin
            if (consumed) begin
                m_valid = 1'b1; m_bpc = m_pc; m_inst = NOP; m_fault = 1'b1;
            end
            m_fault_due = 1'b0;
            m_parked    = 1'b1;
        end else if (m_parked) begin
            if (consumed) m_valid = 1'b0;
        end else if (m_running) begin
            if (consumed) begin
                if (fetch_en) begin
                    m_valid = 1'b1; m_bpc = m_pc; m_inst = mem_word(m_pc / 4); m_fault = 1'b0;
                    m_pc    = m_pc + 4;
                end else begin
                    m_valid   = 1'b0;
                    m_running = 1'b0;
                end
            end
        end else begin
            if (consumed) m_valid = 1'b0;
            if (fetch_en) m_running = 1'b1;
        end
    endtask

    task automatic step();
        m_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_valid"}, {31'b0, id_valid}, 32'd0);
        chk({tag, "_pc"}, id_pc, 32'h0);
        chk({tag, "_pc_plus4"}, id_pc_plus4, 32'h0);
        chk({tag, "_inst"}, id_inst, NOP);
        chk({tag, "_fault"}, {31'b0, id_fault}, 32'd0);
        chk({tag, "_addr"}, inst_mem_read_addr, RPC >> 2);
    endtask

    task automatic chk_bundle(input string tag, input logic [31:0] pc, input logic fault);
        chk({tag, "_valid"}, {31'b0, id_valid}, 32'd1);
        chk({tag, "_pc"}, id_pc, pc);
        chk({tag, "_pc_plus4"}, id_pc_plus4, pc + 32'd4);
        chk({tag, "_inst"}, id_inst, fault ? NOP : mem_word(pc >> 2));
        chk({tag, "_fault"}, {31'b0, id_fault}, {31'b0, fault});
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        fe;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic        ef;
        logic [31:0] eaddr;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(input logic fe, input logic rdy, input logic rv,
                                input logic [31:0] rpc, input logic ev,
                                input logic [31:0] epc, input logic ef,
                                input logic [31:0] eaddr);
        vec_t v;
        v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.ev = ev; v.epc = epc; v.ef = ef; v.eaddr = eaddr;
        return v;
    endfunction

    initial begin
        tbl[0]  = mk(1, 1, 0, 0,        0, 0,        0, 32'h40);
        tbl[1]  = mk(1, 1, 0, 0,        1, 32'h100,  0, 32'h41);
        tbl[2]  = mk(1, 1, 0, 0,        1, 32'h104,  0, 32'h42);
        tbl[3]  = mk(1, 1, 0, 0,        1, 32'h108,  0, 32'h43);
        tbl[4]  = mk(1, 0, 0, 0,        1, 32'h108,  0, 32'h43);
        tbl[5]  = mk(1, 0, 0, 0,        1, 32'h108,  0, 32'h43);
        tbl[6]  = mk(1, 0, 0, 0,        1, 32'h108,  0, 32'h43);
        tbl[7]  = mk(1, 1, 0, 0,        1, 32'h10C,  0, 32'h44);
        tbl[8]  = mk(1, 0, 0, 0,        1, 32'h10C,  0, 32'h44);
        tbl[9]  = mk(1, 0, 1, 32'h200,  0, 0,        0, 32'h80);
        tbl[10] = mk(1, 1, 0, 0,        1, 32'h200,  0, 32'h81);
        tbl[11] = mk(1, 1, 1, 32'h202,  0, 0,        0, 32'h80);
        tbl[12] = mk(1, 1, 0, 0,        1, 32'h202,  1, 32'h80);
        tbl[13] = mk(1, 1, 0, 0,        0, 0,        0, 32'h80);
        tbl[14] = mk(1, 1, 0, 0,        0, 0,        0, 32'h80);
        tbl[15] = mk(1, 1, 1, 32'h300,  0, 0,        0, 32'hC0);
        tbl[16] = mk(1, 1, 0, 0,        1, 32'h300,  0, 32'hC1);

        rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        m_reset();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        chk_reset_values("reset");

        for (int i = 0; i < 17; i++) begin
            fetch_en = tbl[i].fe; id_ready = tbl[i].rdy;
            redirect_valid = tbl[i].rv; redirect_pc = tbl[i].rpc;
            step();
            chk($sformatf("vec%0d_addr", i), inst_mem_read_addr, tbl[i].eaddr);
            if (tbl[i].ev) chk_bundle($sformatf("vec%0d", i), tbl[i].epc, tbl[i].ef);
            else chk($sformatf("vec%0d_valid", i), {31'b0, id_valid}, 32'd0);
        end

        // PC wrap at the top of the address space.
        fetch_en = 1'b1; id_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        chk("wrap_bubble", {31'b0, id_valid}, 32'd0);
        chk("wrap_addr", inst_mem_read_addr, 32'h3FFF_FFFF);
        step();
        chk_bundle("wrap_top", 32'hFFFF_FFFC, 1'b0);
        chk("wrap_top_plus4_zero", id_pc_plus4, 32'h0);
        step();
        chk_bundle("wrap_zero", 32'h0, 1'b0);

        // fetch_en dropped mid-stream: bubbles, pc frozen at 4.
        fetch_en = 1'b0;
        step();
        chk("fe_low_bubble0", {31'b0, id_valid}, 32'd0);
        step();
        chk("fe_low_bubble1", {31'b0, id_valid}, 32'd0);
        chk("fe_low_addr", inst_mem_read_addr, 32'h1);
        fetch_en = 1'b1;
        step();
        chk("fe_resume_bubble", {31'b0, id_valid}, 32'd0);
        step();
        chk_bundle("fe_resume", 32'h4, 1'b0);

        // Asynchronous reset between edges.
        #2;
        rst = 1'b1;
        #1;
        chk_reset_values("async_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        m_reset();
        chk_reset_values("post_rst");

        // Randomized phase against the model.
        for (int c = 0; c < 2000; c++) begin
            int unsigned sel;
            fetch_en       = ($urandom % 8) != 0;
            id_ready       = ($urandom % 3) != 0;
            redirect_valid = ($urandom % 12) == 0;
            sel = $urandom % 8;
            if (sel == 0)      redirect_pc = 32'hFFFF_FFF0 + (($urandom % 4) * 4);
            else if (sel <= 2) redirect_pc = ($urandom % 32'h1000) | 32'h1;
            else               redirect_pc = ($urandom % 32'h1000) & ~32'h3;
            step();
            chk("rnd_addr", inst_mem_read_addr, {2'b00, m_pc[31:2]});
            chk("rnd_valid", {31'b0, id_valid}, {31'b0, m_valid});
            if (m_valid) begin
                chk("rnd_pc", id_pc, m_bpc);
                chk("rnd_pc_plus4", id_pc_plus4, m_bpc + 32'd4);
                chk("rnd_inst", id_inst, m_inst);
                chk("rnd_fault", {31'b0, id_fault}, {31'b0, m_fault});
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
